// File: rtl/trig_coincidence.sv
// N-channel trigger coincidence unit: synchronise, window each rising edge,
// majority-match enabled channels, then emit a fixed pulse followed by dead time.
module trig_coincidence #(
  parameter int NCHAN        = 4,
  parameter int WINDOW_BITS  = 4,
  parameter int HOLDOFF_BITS = 8,
  parameter int OUT_LEN      = 4,
  parameter int CNT_BITS     = 32,
  localparam int TW          = $clog2(NCHAN + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCHAN-1:0]        trig_i,
  input  logic [NCHAN-1:0]        chan_mask_i,
  input  logic [WINDOW_BITS-1:0]  window_i,
  input  logic [TW-1:0]           threshold_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic                    trig_o,
  output logic [CNT_BITS-1:0]     trig_count_o,
  output logic [NCHAN-1:0]        chan_active_o,
  output logic                    busy_o
);

  localparam int WB = WINDOW_BITS + 1;
  localparam int PW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE   = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic [NCHAN-1:0]        s0, s1, prev, rise;
  logic [WB-1:0]           wcnt [NCHAN];
  logic [NCHAN-1:0]        active;
  logic [TW-1:0]           pop;
  logic                    match;
  logic [1:0]              state;
  logic [PW-1:0]           pcnt;
  logic [HOLDOFF_BITS-1:0] hold, hcnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0   <= '0;
      s1   <= '0;
      prev <= '0;
    end else begin
      s0   <= trig_i;
      s1   <= s0;
      prev <= s1;
    end
  end

  assign rise = s1 & ~prev;

  // Match clears every window, so one coincidence yields exactly one trigger.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NCHAN; c++) wcnt[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NCHAN; c++) begin
        if (!chan_mask_i[c] || match)
          wcnt[c] <= '0;
        else if (rise[c] && state == IDLE)
          wcnt[c] <= WB'(window_i) + WB'(1);
        else if (wcnt[c] != '0)
          wcnt[c] <= wcnt[c] - WB'(1);
      end
    end
  end

  always_comb begin
    active = '0;
    pop    = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      active[c] = (wcnt[c] != '0);
      pop       = pop + TW'(active[c] & chan_mask_i[c]);
    end
    match = (state == IDLE) && (threshold_i != '0) && (pop >= threshold_i);
  end

  assign chan_active_o = active;
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      trig_o       <= 1'b0;
      pcnt         <= '0;
      hold         <= '0;
      hcnt         <= '0;
      trig_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state  <= PULSE;
            trig_o <= 1'b1;
            pcnt   <= PW'(OUT_LEN - 1);
            hold   <= holdoff_i;
            if (trig_count_o != '1)
              trig_count_o <= trig_count_o + CNT_BITS'(1);
          end
        end
        PULSE: begin
          if (pcnt == '0) begin
            trig_o <= 1'b0;
            if (hold == '0) begin
              state <= IDLE;
            end else begin
              state <= HOLDOFF;
              hcnt  <= hold - HOLDOFF_BITS'(1);
            end
          end else begin
            pcnt <= pcnt - PW'(1);
          end
        end
        HOLDOFF: begin
          if (hcnt == '0)
            state <= IDLE;
          else
            hcnt <= hcnt - HOLDOFF_BITS'(1);
        end
        default: begin
          state  <= IDLE;
          trig_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_coincidence.sv
// Bench for trig_coincidence: directed scenarios plus random traffic, all checked
// against a timestamp-based reference model of windows and trigger intervals.
module tb_trig_coincidence;

  localparam int NCH   = 4;
  localparam int OLEN  = 4;
  localparam int CBITS = 4;
  localparam int CMAX  = (1 << CBITS) - 1;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] trig = '0;
  logic [3:0] mask = '0;
  logic [3:0] win  = '0;
  logic [2:0] thr  = '0;
  logic [7:0] hold = '0;
  logic       trig_o, busy;
  logic [3:0] count, active;

  trig_coincidence #(
    .NCHAN(NCH),
    .WINDOW_BITS(4),
    .HOLDOFF_BITS(8),
    .OUT_LEN(OLEN),
    .CNT_BITS(CBITS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .trig_i(trig),
    .chan_mask_i(mask),
    .window_i(win),
    .threshold_i(thr),
    .holdoff_i(hold),
    .trig_o(trig_o),
    .trig_count_o(count),
    .chan_active_o(active),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0, passes = 0, fails = 0;

  // Reference model: edge index n, input history, and each channel's window
  // expiry edge; a trigger is the edge it starts at plus its latched holdoff.
  int         n = 0;
  logic [3:0] h0 = '0, h1 = '0, h2 = '0;
  int         expt [NCH];
  bit         has_t = 0;
  int         t_start = 0, t_hold = 0, m_count = 0;

  int pulses = 0;
  bit last_trig = 0;
  int rise_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) expt[c] = 0;
    h0 = '0; h1 = '0; h2 = '0;
    has_t = 0;
    m_count = 0;
  endtask

  task automatic model_edge();
    bit idle, match;
    int pop;
    if (rst) begin
      model_reset();
    end else begin
      idle = !has_t || (n >= t_start + OLEN + t_hold);
      pop = 0;
      for (int c = 0; c < NCH; c++)
        if (expt[c] > n && mask[c]) pop++;
      match = idle && (thr != 0) && (pop >= int'(thr));
      for (int c = 0; c < NCH; c++) begin
        if (!mask[c] || match)           expt[c] = 0;
        else if (h1[c] && !h2[c] && idle) expt[c] = n + 1 + int'(win) + 1;
      end
      if (match) begin
        has_t   = 1;
        t_start = n + 1;
        t_hold  = int'(hold);
        if (m_count < CMAX) m_count++;
      end
      h2 = h1; h1 = h0; h0 = trig;
    end
    n++;
  endtask

  task automatic step();
    logic [3:0] ea;
    bit et, eb;
    @(posedge clk);
    model_edge();
    #1;
    et = has_t && n >= t_start && n < t_start + OLEN;
    eb = has_t && n >= t_start && n < t_start + OLEN + t_hold;
    for (int c = 0; c < NCH; c++) ea[c] = (expt[c] > n);
    chk("trig_o", trig_o, et);
    chk("busy_o", busy, eb);
    chk("chan_active_o", active, ea);
    chk("trig_count_o", count, m_count);
    if (trig_o && !last_trig) begin
      pulses++;
      rise_times.push_back(n);
    end
    last_trig = trig_o;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic coinc(input logic [3:0] a, input logic [3:0] b, input int gap);
    trig = a;
    step();
    repeat (gap - 1) step();
    trig = a | b;
    step();
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, p0, q0, w;

    mask = 4'b0011; thr = 3'd2; win = 4'd3; hold = 8'd10;
    run(3);
    chk("reset_trig", trig_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_active", active, 0);
    chk("reset_count", count, 0);
    rst = 1'b0;
    run(3);

    // ch1 three edges after ch0: windows overlap
    e0 = n + 1;
    coinc(4'b0001, 4'b0010, 3);
    run(30);
    chk("t1_count", count, 1);
    chk("t1_pulses", pulses, 1);
    chk("t1_latency", rise_times[0], e0 + 6);
    trig = '0; run(10);
    // four edges apart: no overlap
    coinc(4'b0001, 4'b0010, 4);
    run(30);
    chk("t1b_count", count, 1);
    trig = '0; run(10);

    trig = 4'b0101; run(20);
    chk("t2_masked_count", count, 1);
    chk("t2_active2", active[2], 0);
    trig = '0; run(5);
    mask = 4'b0101; trig = 4'b0101; run(25);
    chk("t2_unmasked_count", count, 2);
    trig = '0; mask = 4'b0011; run(10);

    p0 = pulses; q0 = rise_times.size();
    for (int k = 0; k < 100; k++) begin
      trig = (k % 5 < 2) ? 4'b0011 : 4'b0000;
      step();
    end
    trig = '0; run(20);
    chk("t3_pulses", pulses - p0, 5);
    chk("t3_count", count, 7);
    for (int i = q0 + 1; i < rise_times.size(); i++)
      chk("t3_spacing", rise_times[i] - rise_times[i-1], 20);

    mask = 4'b1111; thr = 3'd3; trig = 4'b0111; run(25);
    chk("t4_three", count, 8);
    trig = '0; run(5);
    trig = 4'b0011; run(25);
    chk("t4_two", count, 8);
    trig = '0; run(5);
    thr = 3'd0; trig = 4'b1111; run(25);
    chk("t4_thr0", count, 8);
    trig = '0; run(5);
    thr = 3'd5; trig = 4'b1111; run(25);
    chk("t4_thr5", count, 8);
    trig = '0; run(5);

    thr = 3'd2; mask = 4'b0011; trig = 4'b0011;
    w = 0;
    while (!trig_o && w < 20) begin step(); w++; end
    chk("t5_pulse_seen", trig_o, 1);
    step();
    chk("t5_second_high", trig_o, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_trig", trig_o, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_busy", busy, 0);
    model_reset();
    last_trig = 0;
    trig = 4'b0001;
    run(2);
    rst = 1'b0;
    p0 = pulses;
    run(20);
    chk("t5_no_retrigger", pulses - p0, 0);
    chk("t5_count", count, 0);

    hold = 8'd0; trig = '0; run(5);
    p0 = pulses;
    for (int i = 0; i < 17; i++) begin
      trig = 4'b0011; step();
      trig = '0; run(9);
    end
    chk("t6_pulses", pulses - p0, 17);
    chk("t6_saturated", count, CMAX);
    run(10);
    chk("t6_stays", count, CMAX);

    rst = 1'b1; step(); rst = 1'b0;
    for (int blk = 0; blk < 15; blk++) begin
      mask = 4'($urandom);
      thr  = 3'($urandom_range(0, 5));
      win  = 4'($urandom);
      hold = 8'($urandom_range(0, 20));
      if (blk % 4 == 3) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 3) == 0) trig[c] = ~trig[c];
        step();
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
